// File: rtl/csm_pkg.sv
// Shared types and defaults for the two-port locked shared memory.
// Op/status/owner encodings plus width defaults.
package csm_pkg;

  localparam int CSM_ADDR_W = 3;
  localparam int CSM_DATA_W = 8;
  localparam int CSM_CNT_W  = 16;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_HOLD  = 2'd2,
    OP_RELSE = 2'd3
  } csm_op_t;

  typedef enum logic [1:0] {
    ERR_OK        = 2'd0,
    ERR_LOCKED    = 2'd1,
    ERR_NOT_OWNER = 2'd2,
    ERR_COLLIDE   = 2'd3
  } csm_err_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } csm_owner_t;

endpackage

// File: rtl/csm_if.sv
// One request/response port of the shared memory.
// master: req/op/addr/wdata out, rsp/rdata/err in; slave: reverse.
interface csm_if
  import csm_pkg::*;
#(
  parameter int ADDR_W = CSM_ADDR_W,
  parameter int DATA_W = CSM_DATA_W
) ();

  logic              req;
  csm_op_t           op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rsp;
  logic [DATA_W-1:0] rdata;
  csm_err_t          err;

  modport master (
    output req, op, addr, wdata,
    input  rsp, rdata, err
  );

  modport slave (
    input  req, op, addr, wdata,
    output rsp, rdata, err
  );

endinterface

// File: rtl/csm_lock_table.sv
// Per-entry owner registers and held mask for both ports.
// Ins: decoded hold/release + addr per port, collide; outs: verdicts, held_mask.
module csm_lock_table
  import csm_pkg::*;
#(
  parameter int ADDR_W = CSM_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 a_hold,
  input  logic                 a_rel,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic                 b_hold,
  input  logic                 b_rel,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic                 collide,
  output logic                 a_locked,
  output logic                 a_owned,
  output logic                 b_locked,
  output logic                 b_owned,
  output logic [2**ADDR_W-1:0] held_mask
);

  localparam int DEPTH = 2**ADDR_W;

  csm_owner_t owner_q [DEPTH];
  csm_owner_t owner_d [DEPTH];
  logic [DEPTH-1:0] held_q;
  logic [DEPTH-1:0] held_d;

  assign a_locked  = (owner_q[a_addr] == OWN_B);
  assign a_owned   = (owner_q[a_addr] == OWN_A);
  assign b_locked  = (owner_q[b_addr] == OWN_A);
  assign b_owned   = (owner_q[b_addr] == OWN_B);
  assign held_mask = held_q;

  always_comb begin
    owner_d = owner_q;
    held_d  = '0;
    unique case (1'b1)
      a_hold && !a_locked: owner_d[a_addr] = OWN_A;
      a_rel && a_owned:    owner_d[a_addr] = NONE;
      default: ;
    endcase
    // B loses every same-address conflict, so it never touches the table then.
    if (!collide) begin
      unique case (1'b1)
        b_hold && !b_locked: owner_d[b_addr] = OWN_B;
        b_rel && b_owned:    owner_d[b_addr] = NONE;
        default: ;
      endcase
    end
    for (int i = 0; i < DEPTH; i++) begin
      held_d[i] = (owner_d[i] != NONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        owner_q[i] <= NONE;
      end
      held_q <= '0;
    end else begin
      owner_q <= owner_d;
      held_q  <= held_d;
    end
  end

endmodule

// File: rtl/csm_core.sv
// Two-port shared memory with hold/release locking and one-cycle responses.
// Ports: clk, reset_n, a_if/b_if (slave), a/b_err_cnt, held_mask.
module csm_core
  import csm_pkg::*;
#(
  parameter int ADDR_W = CSM_ADDR_W,
  parameter int DATA_W = CSM_DATA_W,
  parameter int CNT_W  = CSM_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  csm_if.slave                 a_if,
  csm_if.slave                 b_if,
  output logic [CNT_W-1:0]     a_err_cnt,
  output logic [CNT_W-1:0]     b_err_cnt,
  output logic [2**ADDR_W-1:0] held_mask
);

  localparam int DEPTH = 2**ADDR_W;

  typedef struct packed {
    csm_err_t          err;
    logic [DATA_W-1:0] rdata;
    logic              wr;
  } res_t;

  function automatic res_t eval(
    input csm_op_t           op,
    input logic              locked,
    input logic              owned,
    input logic [DATA_W-1:0] cur
  );
    res_t r;
    r.err   = ERR_OK;
    r.rdata = '0;
    r.wr    = 1'b0;
    unique case (op)
      OP_READ:  if (locked) r.err = ERR_LOCKED;
                else r.rdata = cur;
      OP_WRITE: if (locked) r.err = ERR_LOCKED;
                else r.wr = 1'b1;
      OP_HOLD:  if (locked) r.err = ERR_LOCKED;
      OP_RELSE: if (!owned) r.err = ERR_NOT_OWNER;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              a_rsp_q, a_rsp_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  csm_err_t          a_err_q, a_err_d;
  logic              b_rsp_q, b_rsp_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  csm_err_t          b_err_q, b_err_d;
  logic [CNT_W-1:0]  a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0]  b_cnt_q, b_cnt_d;

  logic a_locked, a_owned, b_locked, b_owned;
  logic collide;
  res_t a_res, b_res;

  // Two reads of one entry are harmless; anything else there goes to A only.
  assign collide = a_if.req && b_if.req
                && (a_if.addr == b_if.addr)
                && !(a_if.op == OP_READ && b_if.op == OP_READ);

  csm_lock_table #(.ADDR_W(ADDR_W)) u_lock (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_hold    (a_if.req && a_if.op == OP_HOLD),
    .a_rel     (a_if.req && a_if.op == OP_RELSE),
    .a_addr    (a_if.addr),
    .b_hold    (b_if.req && b_if.op == OP_HOLD),
    .b_rel     (b_if.req && b_if.op == OP_RELSE),
    .b_addr    (b_if.addr),
    .collide   (collide),
    .a_locked  (a_locked),
    .a_owned   (a_owned),
    .b_locked  (b_locked),
    .b_owned   (b_owned),
    .held_mask (held_mask)
  );

  always_comb begin
    a_res = eval(a_if.op, a_locked, a_owned, mem_q[a_if.addr]);
    b_res = eval(b_if.op, b_locked, b_owned, mem_q[b_if.addr]);
    if (collide) begin
      b_res.err   = ERR_COLLIDE;
      b_res.rdata = '0;
      b_res.wr    = 1'b0;
    end

    a_rsp_d   = a_if.req;
    a_rdata_d = a_if.req ? a_res.rdata : '0;
    a_err_d   = a_if.req ? a_res.err : ERR_OK;
    b_rsp_d   = b_if.req;
    b_rdata_d = b_if.req ? b_res.rdata : '0;
    b_err_d   = b_if.req ? b_res.err : ERR_OK;

    mem_d = mem_q;
    if (a_if.req && a_res.wr) mem_d[a_if.addr] = a_if.wdata;
    if (b_if.req && b_res.wr) mem_d[b_if.addr] = b_if.wdata;

    a_cnt_d = a_cnt_q;
    if (a_rsp_d && a_err_d != ERR_OK && a_cnt_q != '1) begin
      a_cnt_d = a_cnt_q + CNT_W'(1);
    end
    b_cnt_d = b_cnt_q;
    if (b_rsp_d && b_err_d != ERR_OK && b_cnt_q != '1) begin
      b_cnt_d = b_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      a_rsp_q   <= 1'b0;
      a_rdata_q <= '0;
      a_err_q   <= ERR_OK;
      b_rsp_q   <= 1'b0;
      b_rdata_q <= '0;
      b_err_q   <= ERR_OK;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
    end else begin
      mem_q     <= mem_d;
      a_rsp_q   <= a_rsp_d;
      a_rdata_q <= a_rdata_d;
      a_err_q   <= a_err_d;
      b_rsp_q   <= b_rsp_d;
      b_rdata_q <= b_rdata_d;
      b_err_q   <= b_err_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
    end
  end

  assign a_if.rsp   = a_rsp_q;
  assign a_if.rdata = a_rdata_q;
  assign a_if.err   = a_err_q;
  assign b_if.rsp   = b_rsp_q;
  assign b_if.rdata = b_rdata_q;
  assign b_if.err   = b_err_q;
  assign a_err_cnt  = a_cnt_q;
  assign b_err_cnt  = b_cnt_q;

endmodule

// File: tb/tb_csm_core.sv
// Bench for csm_core: directed vector table, reset corner, random vs model.
// Drives both ports through csm_if instances.
module tb_csm_core;
  import csm_pkg::*;

  logic clk;
  logic reset_n;
  logic [15:0] a_err_cnt, b_err_cnt;
  logic [7:0]  held_mask;

  csm_if a_if ();
  csm_if b_if ();

  csm_core dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_if      (a_if),
    .b_if      (b_if),
    .a_err_cnt (a_err_cnt),
    .b_err_cnt (b_err_cnt),
    .held_mask (held_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: owners 0=none, 1=A, 2=B
  int mem_m [8];
  int own_m [8];
  int acnt_m, bcnt_m;
  int e_arsp, e_ard, e_aerr, e_brsp, e_brd, e_berr, e_held;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mem_m[i] = 0;
      own_m[i] = 0;
    end
    acnt_m = 0;
    bcnt_m = 0;
  endfunction

  function automatic void rule(input int me, input int op, input int owner,
                               input int cur, output int err, output int rd,
                               output bit wr, output int nown);
    int other = 3 - me;
    err = 0; rd = 0; wr = 0; nown = owner;
    if (op == 3) begin
      if (owner == me) nown = 0;
      else err = 2;
    end else if (owner == other) begin
      err = 1;
    end else begin
      case (op)
        0: rd = cur;
        1: wr = 1;
        default: nown = me;
      endcase
    end
  endfunction

  function automatic void model_step(input bit ar, input int aop, input int aad,
                                     input int awd, input bit br, input int bop,
                                     input int bad, input int bwd);
    bit col, aw, bw;
    int an, bn;
    col = ar && br && (aad == bad) && !(aop == 0 && bop == 0);
    rule(1, aop, own_m[aad], mem_m[aad], e_aerr, e_ard, aw, an);
    rule(2, bop, own_m[bad], mem_m[bad], e_berr, e_brd, bw, bn);
    if (!ar) begin e_aerr = 0; e_ard = 0; end
    if (!br) begin e_berr = 0; e_brd = 0; end
    else if (col) begin e_berr = 3; e_brd = 0; end
    e_arsp = ar;
    e_brsp = br;
    if (ar) begin
      if (aw) mem_m[aad] = awd;
      own_m[aad] = an;
    end
    if (br && !col) begin
      if (bw) mem_m[bad] = bwd;
      own_m[bad] = bn;
    end
    if (ar && e_aerr != 0 && acnt_m < 65535) acnt_m++;
    if (br && e_berr != 0 && bcnt_m < 65535) bcnt_m++;
    e_held = 0;
    for (int i = 0; i < 8; i++) if (own_m[i] != 0) e_held |= (1 << i);
  endfunction

  task automatic drive(input bit ar, input int aop, input int aad, input int awd,
                       input bit br, input int bop, input int bad, input int bwd);
    logic [1:0] ao, bo;
    ao = aop[1:0];
    bo = bop[1:0];
    a_if.req = ar; a_if.op = csm_op_t'(ao);
    a_if.addr = aad[2:0]; a_if.wdata = awd[7:0];
    b_if.req = br; b_if.op = csm_op_t'(bo);
    b_if.addr = bad[2:0]; b_if.wdata = bwd[7:0];
  endtask

  // Drive one cycle, advance the model, sample #1 after the edge.
  task automatic cyc(input bit ar, input int aop, input int aad, input int awd,
                     input bit br, input int bop, input int bad, input int bwd);
    drive(ar, aop, aad, awd, br, bop, bad, bwd);
    model_step(ar, aop, aad, awd, br, bop, bad, bwd);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " a_rsp"},   32'(a_if.rsp),   e_arsp);
    chk({tag, " a_rdata"}, 32'(a_if.rdata), e_ard);
    chk({tag, " a_err"},   32'(a_if.err),   e_aerr);
    chk({tag, " b_rsp"},   32'(b_if.rsp),   e_brsp);
    chk({tag, " b_rdata"}, 32'(b_if.rdata), e_brd);
    chk({tag, " b_err"},   32'(b_if.err),   e_berr);
    chk({tag, " held"},    32'(held_mask),  e_held);
    chk({tag, " a_cnt"},   32'(a_err_cnt),  acnt_m);
    chk({tag, " b_cnt"},   32'(b_err_cnt),  bcnt_m);
  endtask

  typedef struct {
    int ar, aop, aad, awd, br, bop, bad, bwd;
    int aerr, ard, berr, brd, held, acnt, bcnt;
  } vec_t;

  vec_t tbl [$];

  initial begin
    // ops: 0 rd 1 wr 2 hold 3 rel; errs: 0 ok 1 locked 2 not_owner 3 collide
    tbl.push_back('{1,1,3,'h5A, 0,0,0,0,     0,0,    0,0,    'h00,0,0});
    tbl.push_back('{1,0,3,0,    0,0,0,0,     0,'h5A, 0,0,    'h00,0,0});
    tbl.push_back('{1,2,2,0,    0,0,0,0,     0,0,    0,0,    'h04,0,0});
    tbl.push_back('{0,0,0,0,    1,1,2,'hFF,  0,0,    1,0,    'h04,0,1});
    tbl.push_back('{0,0,0,0,    1,0,2,0,     0,0,    1,0,    'h04,0,2});
    tbl.push_back('{1,0,2,0,    0,0,0,0,     0,0,    0,0,    'h04,0,2});
    tbl.push_back('{1,1,5,'h77, 0,0,0,0,     0,0,    0,0,    'h04,0,2});
    tbl.push_back('{1,2,5,0,    0,0,0,0,     0,0,    0,0,    'h24,0,2});
    tbl.push_back('{1,3,5,0,    0,0,0,0,     0,0,    0,0,    'h04,0,2});
    tbl.push_back('{0,0,0,0,    1,0,5,0,     0,0,    0,'h77, 'h04,0,2});
    tbl.push_back('{1,2,1,0,    0,0,0,0,     0,0,    0,0,    'h06,0,2});
    tbl.push_back('{0,0,0,0,    1,3,1,0,     0,0,    2,0,    'h06,0,3});
    tbl.push_back('{1,1,4,'h11, 1,1,4,'h22,  0,0,    3,0,    'h06,0,4});
    tbl.push_back('{1,0,4,0,    0,0,0,0,     0,'h11, 0,0,    'h06,0,4});
    tbl.push_back('{1,2,6,0,    1,0,6,0,     0,0,    3,0,    'h46,0,5});
    tbl.push_back('{0,0,0,0,    1,0,6,0,     0,0,    1,0,    'h46,0,6});
    tbl.push_back('{1,0,3,0,    1,0,3,0,     0,'h5A, 0,'h5A, 'h46,0,6});
    tbl.push_back('{1,3,2,0,    0,0,0,0,     0,0,    0,0,    'h42,0,6});
    tbl.push_back('{1,3,2,0,    0,0,0,0,     2,0,    0,0,    'h42,1,6});
    tbl.push_back('{0,0,0,0,    1,2,6,0,     0,0,    1,0,    'h42,1,7});
    tbl.push_back('{0,0,0,0,    1,2,7,0,     0,0,    0,0,    'hC2,1,7});
    tbl.push_back('{1,0,7,0,    0,0,0,0,     1,0,    0,0,    'hC2,2,7});
    tbl.push_back('{1,1,0,'h44, 1,1,7,'h33,  0,0,    0,0,    'hC2,2,7});
    tbl.push_back('{1,0,0,0,    1,0,7,0,     0,'h44, 0,'h33, 'hC2,2,7});

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst a_rsp",   32'(a_if.rsp),   0);
    chk("rst a_rdata", 32'(a_if.rdata), 0);
    chk("rst a_err",   32'(a_if.err),   0);
    chk("rst b_rsp",   32'(b_if.rsp),   0);
    chk("rst b_err",   32'(b_if.err),   0);
    chk("rst held",    32'(held_mask),  0);
    chk("rst a_cnt",   32'(a_err_cnt),  0);
    chk("rst b_cnt",   32'(b_err_cnt),  0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      vec_t v;
      string t;
      v = tbl[i];
      t = $sformatf("vec%0d", i);
      cyc(v.ar[0], v.aop, v.aad, v.awd, v.br[0], v.bop, v.bad, v.bwd);
      chk({t, " a_rsp"},   32'(a_if.rsp),   v.ar);
      chk({t, " a_rdata"}, 32'(a_if.rdata), v.ard);
      chk({t, " a_err"},   32'(a_if.err),   v.aerr);
      chk({t, " b_rsp"},   32'(b_if.rsp),   v.br);
      chk({t, " b_rdata"}, 32'(b_if.rdata), v.brd);
      chk({t, " b_err"},   32'(b_if.err),   v.berr);
      chk({t, " held"},    32'(held_mask),  v.held);
      chk({t, " a_cnt"},   32'(a_err_cnt),  v.acnt);
      chk({t, " b_cnt"},   32'(b_err_cnt),  v.bcnt);
    end

    // Reset lands in the cycle of a pending HOLD: nothing may come back.
    cyc(1, 1, 0, 'hAA, 0, 0, 0, 0);
    chk("mid wr a_err", 32'(a_if.err), 0);
    drive(1, 2, 0, 0, 1, 0, 3, 0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid a_rsp", 32'(a_if.rsp),  0);
    chk("mid b_rsp", 32'(b_if.rsp),  0);
    chk("mid held",  32'(held_mask), 0);
    chk("mid a_cnt", 32'(a_err_cnt), 0);
    chk("mid b_cnt", 32'(b_err_cnt), 0);
    @(posedge clk);
    #1;
    chk("mid2 a_rsp", 32'(a_if.rsp), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("post a_rsp", 32'(a_if.rsp), 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("post rd0 rsp",   32'(a_if.rsp),   1);
    chk("post rd0 rdata", 32'(a_if.rdata), 0);
    chk("post rd0 err",   32'(a_if.err),   0);
    chk("post held",      32'(held_mask),  0);

    for (int n = 0; n < 500; n++) begin
      bit ar, br;
      int aad, bad;
      ar  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 3) != 0);
      aad = $urandom_range(0, 7);
      bad = ($urandom_range(0, 1) != 0) ? aad : int'($urandom_range(0, 7));
      cyc(ar, $urandom_range(0, 3), aad, $urandom_range(0, 255),
          br, $urandom_range(0, 3), bad, $urandom_range(0, 255));
      check_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
